// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM data-memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned ADDR_BASE_DEF = 1024;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned HALF_W        = 16;
  // Wait-state counter width; covers WAIT_CYCLES up to 15.
  localparam int unsigned CNT_W         = 4;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter shared by the LO and HI half-word phases.
module sram_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Clear has priority so the terminal count rolls straight back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases with wait states.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dq_out,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  state_e                   state_d, state_q;
  logic                     op_wr_d, op_wr_q;
  logic [WORD_W-1:0]        word_d, word_q;
  logic [DATA_W-1:0]        wdata_d, wdata_q;
  logic [DATA_W-1:0]        rdata_d, rdata_q;
  logic [SRAM_ADDR_W-1:0]   sram_addr_d, sram_addr_q;
  logic [HALF_W-1:0]        sram_dq_out_d, sram_dq_out_q;
  logic                     sram_dq_oe_d, sram_dq_oe_q;
  logic                     sram_we_n_d, sram_we_n_q;

  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     cnt_last;
  logic                     cnt_clear;
  logic                     cnt_en;
  logic                     in_phase;
  logic                     next_in_phase;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt),
    .last   (cnt_last)
  );

  // FSM next state, request latching, read-half capture and pipeline freeze.
  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    cnt_en    = 1'b0;
    cnt_clear = 1'b1;
    unique case (state_q)
      IDLE: begin
        // Combinational so the pipeline freezes in the request cycle itself.
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          state_d = LO;
          op_wr_d = wr_en;
          word_d  = WORD_W'((address - DATA_W'(ADDR_BASE)) >> 2);
          wdata_d = write_data;
        end
      end
      LO: begin
        cnt_en    = 1'b1;
        cnt_clear = cnt_last;
        if (cnt_last) begin
          state_d = HI;
          if (!op_wr_q) begin
            rdata_d[HALF_W-1:0] = sram_dq_in;
          end
        end
      end
      HI: begin
        cnt_en    = 1'b1;
        cnt_clear = cnt_last;
        if (cnt_last) begin
          state_d = DONE;
          if (!op_wr_q) begin
            rdata_d[DATA_W-1:HALF_W] = sram_dq_in;
          end
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pin values for the coming cycle, derived from next state and next count.
  always_comb begin
    in_phase      = (state_q == LO) || (state_q == HI);
    next_in_phase = (state_d == LO) || (state_d == HI);
    cnt_nxt       = (in_phase && !cnt_last) ? (cnt + CNT_W'(1)) : '0;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    if (next_in_phase) begin
      sram_addr_d = {word_d, (state_d == HI) ? HALF_HI : HALF_LO};
      if (op_wr_d) begin
        sram_dq_out_d = (state_d == HI) ? wdata_d[DATA_W-1:HALF_W] : wdata_d[HALF_W-1:0];
        sram_dq_oe_d  = 1'b1;
        // Strobe released on the last phase cycle for hold time, unless the phase is one cycle.
        sram_we_n_d   = (WAIT_CYCLES > 1) && (cnt_nxt == CNT_W'(WAIT_CYCLES - 1));
      end
    end
  end

  // State, latched request and registered SRAM pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_wr_q       <= op_wr_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign read_data   = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: SRAM behavioural models plus a read_data scoreboard.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Instance with 5 wait states.
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  // Instance with 1 wait state.
  logic        rd_en1 = 1'b0, wr_en1 = 1'b0;
  logic [31:0] address1 = '0, write_data1 = '0;
  logic [31:0] read_data1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1;

  // SRAM models and preload ports.
  logic [15:0] mem  [0:255];
  logic [15:0] mem1 [0:3];
  logic        pl_en = 1'b0, pl1_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  logic [31:0] exp_q  [$];
  logic [31:0] exp1_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  sram_mem_controller #(.ADDR_BASE(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_mem_controller #(.ADDR_BASE(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1),
    .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
  );

  assign sram_dq_in  = mem[sram_addr[7:0]];
  assign sram_dq_in1 = mem1[sram_addr1[1:0]];

  // Asynchronous SRAM: write while strobe low and bus driven.
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  always @(posedge clk) begin
    if (pl1_en) mem1[pl_a[1:0]] <= pl_d;
    else if (!sram_we_n1 && sram_dq_oe1) mem1[sram_addr1[1:0]] <= sram_dq_out1;
  end

  task automatic preload(input bit sel, input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_a = a; pl_d = d;
    if (sel) pl1_en = 1'b1; else pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0; pl1_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready); end
    n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b exp 1", sram_we_n); end
    n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b exp 0", sram_dq_oe); end
    n_tests++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h exp 0", sram_addr); end
    n_tests++; if (sram_dq_out !== 16'd0) begin n_fail++; $display("FAIL reset_dq_out: got %h exp 0", sram_dq_out); end
    n_tests++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_data: got %h exp 0", read_data); end
    rst = 1'b1;
  endtask

  task automatic test_read;
    logic [17:0] ea;
    logic [31:0] e;
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin rd_en = 1'b1; address = 32'd1024; exp_q.push_back(32'hDEADBEEF); end
      if (c == 1) rd_en = 1'b0;
      @(negedge clk);
      n_tests++; if (ready !== (c == 11)) begin n_fail++; $display("FAIL read_ready c=%0d: got %b exp %b", c, ready, (c == 11)); end
      if (c >= 1 && c <= 10) begin
        ea = (c <= 5) ? 18'd0 : 18'd1;
        n_tests++; if (sram_addr !== ea) begin n_fail++; $display("FAIL read_addr c=%0d: got %h exp %h", c, sram_addr, ea); end
        n_tests++; if ({sram_we_n, sram_dq_oe} !== 2'b10) begin n_fail++; $display("FAIL read_pins c=%0d: got we_n=%b oe=%b exp 1/0", c, sram_we_n, sram_dq_oe); end
      end
      if (c == 11) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL read_sb: queue empty"); end
        else begin
          e = exp_q.pop_front();
          if (read_data !== e) begin n_fail++; $display("FAIL read_data: got %h exp %h", read_data, e); end
        end
      end
    end
  endtask

  task automatic test_write;
    logic [17:0] ea;
    logic [15:0] ed;
    logic [31:0] e;
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        wr_en = 1'b1; address = 32'd1032; write_data = 32'h12345678;
        exp_q.push_back(32'hDEADBEEF);
      end
      if (c == 1) wr_en = 1'b0;
      @(negedge clk);
      n_tests++; if (ready !== (c == 11)) begin n_fail++; $display("FAIL write_ready c=%0d: got %b exp %b", c, ready, (c == 11)); end
      if (c >= 1 && c <= 10) begin
        ea = (c <= 5) ? 18'd4 : 18'd5;
        ed = (c <= 5) ? 16'h5678 : 16'h1234;
        n_tests++; if (sram_addr !== ea) begin n_fail++; $display("FAIL write_addr c=%0d: got %h exp %h", c, sram_addr, ea); end
        n_tests++; if (sram_dq_out !== ed) begin n_fail++; $display("FAIL write_dq c=%0d: got %h exp %h", c, sram_dq_out, ed); end
        n_tests++; if (sram_dq_oe !== 1'b1) begin n_fail++; $display("FAIL write_oe c=%0d: got %b exp 1", c, sram_dq_oe); end
        n_tests++; if (sram_we_n !== (((c - 1) % 5) == 4)) begin n_fail++; $display("FAIL write_we_n c=%0d: got %b exp %b", c, sram_we_n, (((c - 1) % 5) == 4)); end
      end
      if (c == 11) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL write_sb: queue empty"); end
        else begin
          e = exp_q.pop_front();
          if (read_data !== e) begin n_fail++; $display("FAIL write_read_data: got %h exp %h", read_data, e); end
        end
        n_tests++; if ({mem[5], mem[4]} !== 32'h12345678) begin n_fail++; $display("FAIL write_mem: got %h exp 12345678", {mem[5], mem[4]}); end
        n_tests++; if ({sram_we_n, sram_dq_oe} !== 2'b10) begin n_fail++; $display("FAIL write_done_pins: got we_n=%b oe=%b exp 1/0", sram_we_n, sram_dq_oe); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    preload(1'b0, 8'd2, 16'hCAFE);
    preload(1'b0, 8'd3, 16'hF00D);
    for (int c = 0; c <= 23; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin rd_en = 1'b1; address = 32'd1024; exp_q.push_back(32'hDEADBEEF); end
      if (c == 11) begin address = 32'd1028; exp_q.push_back(32'hF00DCAFE); end
      if (c == 13) rd_en = 1'b0;
      @(negedge clk);
      n_tests++; if (ready !== (c == 11 || c == 23)) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b exp %b", c, ready, (c == 11 || c == 23)); end
      if (c >= 13 && c <= 22) begin
        n_tests++; if (sram_addr !== ((c <= 17) ? 18'd2 : 18'd3)) begin n_fail++; $display("FAIL b2b_addr c=%0d: got %h exp %h", c, sram_addr, ((c <= 17) ? 18'd2 : 18'd3)); end
      end
      if (c == 11 || c == 23) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb c=%0d: queue empty", c); end
        else begin
          e = exp_q.pop_front();
          if (read_data !== e) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h exp %h", c, read_data, e); end
        end
      end
    end
  endtask

  task automatic test_rw_both;
    logic [31:0] e;
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1040; write_data = 32'hA5A55A5A;
        exp_q.push_back(32'hF00DCAFE);
      end
      if (c == 1) begin rd_en = 1'b0; wr_en = 1'b0; end
      @(negedge clk);
      n_tests++; if (ready !== (c == 11)) begin n_fail++; $display("FAIL rw_ready c=%0d: got %b exp %b", c, ready, (c == 11)); end
      if (c == 1) begin
        n_tests++; if ({sram_we_n, sram_dq_oe} !== 2'b01) begin n_fail++; $display("FAIL rw_pins: got we_n=%b oe=%b exp 0/1", sram_we_n, sram_dq_oe); end
      end
      if (c == 11) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rw_sb: queue empty"); end
        else begin
          e = exp_q.pop_front();
          if (read_data !== e) begin n_fail++; $display("FAIL rw_read_data: got %h exp %h", read_data, e); end
        end
        n_tests++; if ({mem[9], mem[8]} !== 32'hA5A55A5A) begin n_fail++; $display("FAIL rw_mem: got %h exp a5a55a5a", {mem[9], mem[8]}); end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin wr_en = 1'b1; address = 32'd1048; write_data = 32'h11112222; end
      if (c == 1) wr_en = 1'b0;
      @(negedge clk);
      n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready c=%0d: got %b exp 0", c, ready); end
    end
    // Third cycle of the HI phase: strobe active.
    @(posedge clk); #1;
    n_tests++; if ({sram_we_n, sram_dq_oe, sram_addr} !== {2'b01, 18'd13}) begin n_fail++; $display("FAIL rst_mid_pre: got we_n=%b oe=%b addr=%h exp 0/1/13", sram_we_n, sram_dq_oe, sram_addr); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_we_n: got %b exp 1", sram_we_n); end
    n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe: got %b exp 0", sram_dq_oe); end
    n_tests++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_read_data: got %h exp 0", read_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++; if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin n_fail++; $display("FAIL rst_mid_after c=%0d: got ready=%b we_n=%b oe=%b exp 1/1/0", c, ready, sram_we_n, sram_dq_oe); end
    end
  endtask

  task automatic test_wait1_wrap;
    logic [31:0] e;
    preload(1'b1, 8'd0, 16'h3333);
    preload(1'b1, 8'd1, 16'h4444);
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin rd_en1 = 1'b1; address1 = 32'd1024 + 32'd4 * (32'd1 << 17); exp1_q.push_back(32'h44443333); end
      if (c == 1) rd_en1 = 1'b0;
      @(negedge clk);
      n_tests++; if (ready1 !== (c == 3 || c == 4)) begin n_fail++; $display("FAIL w1_ready c=%0d: got %b exp %b", c, ready1, (c == 3 || c == 4)); end
      if (c == 1 || c == 2) begin
        n_tests++; if (sram_addr1 !== 18'(c - 1)) begin n_fail++; $display("FAIL w1_addr c=%0d: got %h exp %h", c, sram_addr1, 18'(c - 1)); end
      end
      if (c == 3) begin
        n_tests++;
        if (exp1_q.size() == 0) begin n_fail++; $display("FAIL w1_sb: queue empty"); end
        else begin
          e = exp1_q.pop_front();
          if (read_data1 !== e) begin n_fail++; $display("FAIL w1_data: got %h exp %h", read_data1, e); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    preload(1'b0, 8'd0, 16'hBEEF);
    preload(1'b0, 8'd1, 16'hDEAD);
    test_read();
    test_write();
    test_back_to_back();
    test_rw_both();
    test_reset_mid_write();
    test_wait1_wrap();
    n_tests++; if (exp_q.size() + exp1_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries exp 0", exp_q.size() + exp1_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
